// File: rtl/seq_detector_p.sv
// seq_detector_p: parametrised Moore serial-pattern detector.
// The match state S records how many leading bits of PATTERN the most recent
// accepted bits reproduce. F is asserted while S holds a full match.
// The next-state table is derived from PATTERN at elaboration using the
// KMP failure rule. Nothing is stored at run time except S and COUNT.
// OVERLAP selects the history after a hit:
//   1 - keep the whole match, so overlapping occurrences are detected.
//   0 - restart from the new bit alone.
// Optional feature macro SEQ_DET_COUNT_EN:
//   defined   - builds a saturating detection counter on COUNT.
//   undefined - ties COUNT to 0 and builds no counter flops.
//               The port list does not change.

module seq_detector_p #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           EN,
    input  logic                           CLR,
    input  logic                           x,
    output logic                           F,
    output logic [$clog2(PATTERN_W+1)-1:0] S,
    output logic [CNT_W-1:0]               COUNT
);

    localparam int SW = $clog2(PATTERN_W + 1);

    // Bit i of the pattern in arrival order (i = 0 is the first bit expected).
    function automatic bit pat_bit(input int i);
        logic [PATTERN_W-1:0] sh;
        sh = PATTERN >> (PATTERN_W - 1 - i);
        return sh[0];
    endfunction

    // Longest suffix of the history that is also a prefix of the pattern.
    // The history is the matched prefix of length k followed by bit b.
    // The exception is a non-overlapping instance that has just hit;
    // there the history is b alone.
    function automatic int kmp_next(input int k, input bit b);
        int best;
        int idx;
        bit ok;
        bit hb;
        best = 0;
        if (!OVERLAP && k == PATTERN_W) begin
            best = (b == pat_bit(0)) ? 1 : 0;
        end else begin
            for (int m = 1; m <= PATTERN_W; m++) begin
                if (m <= k + 1) begin
                    ok = 1'b1;
                    for (int i = 0; i < m; i++) begin
                        idx = k + 1 - m + i;
                        if (idx == k) hb = b;
                        else          hb = pat_bit(idx);
                        if (hb != pat_bit(i)) ok = 1'b0;
                    end
                    if (ok) best = m;
                end
            end
        end
        return best;
    endfunction

    // Transition table, one entry per (state, input bit).
    // Every entry is an elaboration-time constant.
    logic [SW-1:0] tab0 [PATTERN_W+1];
    logic [SW-1:0] tab1 [PATTERN_W+1];

    for (genvar k = 0; k <= PATTERN_W; k++) begin : g_tab
        localparam logic [SW-1:0] NXT0 = SW'(kmp_next(k, 1'b0));
        localparam logic [SW-1:0] NXT1 = SW'(kmp_next(k, 1'b1));
        assign tab0[k] = NXT0;
        assign tab1[k] = NXT1;
    end

    logic [SW-1:0] s_next;

    // Next-state lookup; a state outside 0..PATTERN_W falls back to 0.
    always_comb begin
        // NOTE: default first so every path assigns s_next and no latch is inferred.
        s_next = '0;
        for (int k = 0; k <= PATTERN_W; k++) begin
            if (S == SW'(k)) s_next = x ? tab1[k] : tab0[k];
        end
    end

    // Match-state register: async reset, sync clear over enable, hold when idle.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (RESET)    S <= '0;
        else if (CLR) S <= '0;
        else if (EN)  S <= s_next;
    end

    // Moore output: depends on S only, never directly on x.
    assign F = (S == SW'(PATTERN_W));

`ifdef SEQ_DET_COUNT_EN
    logic hit;
    assign hit = EN && !CLR && (s_next == SW'(PATTERN_W));

    // Saturating detection counter, cleared together with S.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                   COUNT <= '0;
        else if (CLR)                COUNT <= '0;
        else if (hit && COUNT != '1) COUNT <= COUNT + CNT_W'(1);
    end
`else
    assign COUNT = '0;
`endif

endmodule

// File: tb/tb_seq_detector_p.sv
// Scoreboard bench for seq_detector_p.
// Three instances share one stimulus stream:
//   u_ov - OVERLAP=1
//   u_no - OVERLAP=0
//   u_c2 - OVERLAP=1, CNT_W=2
// The driver pushes hand-computed expectations into a queue.
// The monitor pops and compares one entry after each clock edge,
// or immediately when an asynchronous reset is being checked.

module tb_seq_detector_p;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic EN = 1'b0;
    logic CLR = 1'b0;
    logic x = 1'b0;

    logic       f_ov, f_no, f_c2;
    logic [2:0] s_ov, s_no, s_c2;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_c2;

    always #5 CLK = ~CLK;

    seq_detector_p #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .x(x),
        .F(f_ov), .S(s_ov), .COUNT(cnt_ov)
    );

    seq_detector_p #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .x(x),
        .F(f_no), .S(s_no), .COUNT(cnt_no)
    );

    seq_detector_p #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .x(x),
        .F(f_c2), .S(s_c2), .COUNT(cnt_c2)
    );

    typedef struct {
        string tag;
        int    s_ov;
        int    s_no;
        int    c_ov;
        int    c_no;
        int    c_c2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    event async_ev;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or async_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, " ov.S"},     int'(s_ov),   e.s_ov);
                check({e.tag, " ov.F"},     int'(f_ov),   int'(e.s_ov == 4));
                check({e.tag, " ov.COUNT"}, int'(cnt_ov), CNT_ON ? e.c_ov : 0);
                check({e.tag, " no.S"},     int'(s_no),   e.s_no);
                check({e.tag, " no.F"},     int'(f_no),   int'(e.s_no == 4));
                check({e.tag, " no.COUNT"}, int'(cnt_no), CNT_ON ? e.c_no : 0);
                check({e.tag, " c2.S"},     int'(s_c2),   e.s_ov);
                check({e.tag, " c2.F"},     int'(f_c2),   int'(e.s_ov == 4));
                check({e.tag, " c2.COUNT"}, int'(cnt_c2), CNT_ON ? e.c_c2 : 0);
            end
        end
    end

    // One clocked step: apply inputs away from the edge and queue the post-edge state.
    task automatic step(input string tag, input logic en, input logic clr, input logic xb,
                        input int e_ov, input int e_no, input int c_ov, input int c_no,
                        input int c_c2);
        exp_t e;
        @(negedge CLK);
        EN  = en;
        CLR = clr;
        x   = xb;
        e = '{tag, e_ov, e_no, c_ov, c_no, c_c2};
        q.push_back(e);
    endtask

    // Assert reset between edges and check that the outputs clear immediately.
    task automatic rst_check(input string tag);
        exp_t e;
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        EN    = 1'b0;
        CLR   = 1'b0;
        e = '{tag, 0, 0, 0, 0, 0};
        q.push_back(e);
        -> async_ev;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        rst_check("reset");

        // Overlapping vs non-overlapping stream 1,0,1,1,0,1,1.
        step("a1", 1, 0, 1, 1, 1, 0, 0, 0);
        step("a2", 1, 0, 0, 2, 2, 0, 0, 0);
        step("a3", 1, 0, 1, 3, 3, 0, 0, 0);
        step("a4", 1, 0, 1, 4, 4, 1, 1, 1);
        step("a5", 1, 0, 0, 2, 0, 1, 1, 1);
        step("a6", 1, 0, 1, 3, 1, 1, 1, 1);
        step("a7", 1, 0, 1, 4, 1, 2, 1, 2);

        // Enable low: everything holds, F stays high on the overlapping instance.
        step("hold1", 0, 0, 1, 4, 1, 2, 1, 2);
        step("hold2", 0, 0, 0, 4, 1, 2, 1, 2);
        step("hold3", 0, 0, 1, 4, 1, 2, 1, 2);
        step("resume", 1, 0, 0, 2, 2, 2, 1, 2);

        // Reach S=3, then reset mid-pattern.
        step("pre_rst", 1, 0, 1, 3, 3, 2, 1, 2);
        rst_check("mid_reset");
        step("r1", 1, 0, 1, 1, 1, 0, 0, 0);
        step("r2", 1, 0, 0, 2, 2, 0, 0, 0);
        step("r3", 1, 0, 1, 3, 3, 0, 0, 0);
        step("r4", 1, 0, 1, 4, 4, 1, 1, 1);

        // Four more separate matches: the 2-bit counter saturates at 3.
        for (int p = 2; p <= 5; p++) begin
            int c2_prev;
            int c2_now;
            c2_prev = (p - 1 > 3) ? 3 : p - 1;
            c2_now  = (p > 3) ? 3 : p;
            step("m1", 1, 0, 1, 1, 1, p - 1, p - 1, c2_prev);
            step("m2", 1, 0, 0, 2, 2, p - 1, p - 1, c2_prev);
            step("m3", 1, 0, 1, 3, 3, p - 1, p - 1, c2_prev);
            step("m4", 1, 0, 1, 4, 4, p, p, c2_now);
        end

        // Clear wins even when x would complete the pattern.
        step("c1", 1, 0, 1, 1, 1, 5, 5, 3);
        step("c2", 1, 0, 0, 2, 2, 5, 5, 3);
        step("c3", 1, 0, 1, 3, 3, 5, 5, 3);
        step("clr", 1, 1, 1, 0, 0, 0, 0, 0);
        step("post1", 1, 0, 1, 1, 1, 0, 0, 0);
        step("clr_en0", 0, 1, 1, 0, 0, 0, 0, 0);
        step("post2", 1, 0, 1, 1, 1, 0, 0, 0);
        step("post3", 1, 0, 1, 1, 1, 0, 0, 0);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        #2;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
